axi4lite_master_if: RTL

- Single-outstanding AXI4-Lite master that turns the memory stage's level-style load/store requests into AXI4-Lite transactions.
- Sits directly downstream of the memory stage:
  - consumes its write_start/addr/data/strobe and read_start/addr;
  - returns write_busy/read_busy, which the memory stage ORs into its pipeline stall;
  - returns read_data, which the memory stage lane-selects and extends.
- On the other side it drives the SoC AXI4-Lite interconnect.

---
 rtl/axi4lite_master_if_pkg.sv | 39 +++
 rtl/axi4lite_master_if.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master_if_pkg.sv
// Shared definitions for axi4lite_master_if.
// - FSM state encoding
// - AXI4-Lite response codes
// - default protection value
// - latched request record
package axi4lite_master_if_pkg;

  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Request captured in IDLE; reads only use the address field.
  typedef struct packed {
    logic [31:0]   addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } mem_req_t;

  // Anything other than OKAY is reported as a bus error, EXOKAY included.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4lite_master_if.sv
// Single-outstanding AXI4-Lite master behind the memory stage.
// Turns level-style load/store requests into one AXI4-Lite transaction at a
// time and stalls the pipeline through write_busy/read_busy until it ends.
//
// Ports
//   clk, rst_n                  core clock, async active-low reset
//   write_start/addr/data/strobe  store request level and payload
//   write_busy                  store in progress (pipeline stall)
//   read_start/addr             load request level and address
//   read_data, read_busy        last completed read data, load stall
//   m_axi_aw*/w*/b*/ar*/r*      AXI4-Lite master channels
//
// Optional macro AXI_RESP_ERR_EN adds bus_error (one-cycle pulse in DONE on
// a non-OKAY response) and bus_error_addr (address of the faulting request).
module axi4lite_master_if
  import axi4lite_master_if_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] AXI_PROT   = AXI_PROT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_start,
  input  logic [31:0]             write_addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  output logic                    write_busy,
  input  logic                    read_start,
  input  logic [31:0]             read_addr,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_busy,
`ifdef AXI_RESP_ERR_EN
  output logic                    bus_error,
  output logic [31:0]             bus_error_addr,
`endif
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_t          state_q, state_d;
  mem_req_t        req_q, req_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            arvalid_q, arvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

`ifdef AXI_RESP_ERR_EN
  logic [1:0]      resp_q, resp_d;
  logic [31:0]     err_addr_q, err_addr_d;
`else
  logic            unused_resp;
  assign unused_resp = ^{m_axi_bresp, m_axi_rresp};
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    rdata_d      = rdata_q;
    write_busy   = 1'b0;
    read_busy    = 1'b0;
    m_axi_bready = 1'b0;
    m_axi_rready = 1'b0;
`ifdef AXI_RESP_ERR_EN
    resp_d       = resp_q;
    err_addr_d   = err_addr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // Combinational so the stall lands in the request cycle itself.
        write_busy = write_start;
        read_busy  = read_start & ~write_start;
        if (write_start) begin
          req_d     = '{addr: write_addr, data: write_data, strb: write_strobe};
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_WR_REQ;
        end else if (read_start) begin
          req_d.addr = read_addr;
          arvalid_d  = 1'b1;
          state_d    = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        write_busy = 1'b1;
        // AW and W retire independently; leave once neither is pending.
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready))
          state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        write_busy   = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_d = ST_DONE;
`ifdef AXI_RESP_ERR_EN
          resp_d = m_axi_bresp;
          if (resp_is_err(m_axi_bresp)) err_addr_d = req_q.addr;
`endif
        end
      end
      ST_RD_REQ: begin
        read_busy = 1'b1;
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        read_busy    = 1'b1;
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          state_d = ST_DONE;
`ifdef AXI_RESP_ERR_EN
          resp_d = m_axi_rresp;
          if (resp_is_err(m_axi_rresp)) err_addr_d = req_q.addr;
`endif
        end
      end
      // One cycle with both stalls low lets the pipeline retire the
      // instruction that is still presenting its start level.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rdata_q    <= '0;
`ifdef AXI_RESP_ERR_EN
      resp_q     <= AXI_RESP_OKAY;
      err_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      rdata_q    <= rdata_d;
`ifdef AXI_RESP_ERR_EN
      resp_q     <= resp_d;
      err_addr_q <= err_addr_d;
`endif
    end
  end

  assign m_axi_awaddr  = req_q.addr[ADDR_WIDTH-1:0];
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = req_q.data;
  assign m_axi_wstrb   = req_q.strb;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_araddr  = req_q.addr[ADDR_WIDTH-1:0];
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_arvalid = arvalid_q;
  assign read_data     = rdata_q;

`ifdef AXI_RESP_ERR_EN
  assign bus_error      = (state_q == ST_DONE) && resp_is_err(resp_q);
  assign bus_error_addr = err_addr_q;
`endif

endmodule
